// File: rtl/pixel_op_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pixel_op_pkg                                            |
// | Purpose  : Shared mode encodings, pixel type and saturating helper |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package pixel_op_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_BRIGHT = 2'd1;
    localparam logic [1:0] MODE_GRAY   = 2'd2;
    localparam logic [1:0] MODE_THRESH = 2'd3;

    // Channels are carried at the widest supported depth and narrowed at use.
    localparam int c_MAX_DW = 32;

    typedef struct packed {
        logic [c_MAX_DW-1:0] r;
        logic [c_MAX_DW-1:0] g;
        logic [c_MAX_DW-1:0] b;
    } pixel_t;

    function automatic logic [c_MAX_DW-1:0] sat_addsub(
        input  logic [c_MAX_DW-1:0] c,
        input  logic [c_MAX_DW-1:0] v,
        input  logic [c_MAX_DW-1:0] max_val,
        input  logic                sub,
        output logic                clip
    );
        logic [c_MAX_DW:0]   s;
        logic [c_MAX_DW-1:0] res;
        if (sub) begin
            s    = {1'b0, c} - {1'b0, v};
            clip = s[c_MAX_DW];
            res  = clip ? '0 : s[c_MAX_DW-1:0];
        end else begin
            s    = {1'b0, c} + {1'b0, v};
            clip = (s > {1'b0, max_val});
            res  = clip ? max_val : s[c_MAX_DW-1:0];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_op_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pixel_op_alu                                            |
// | Purpose  : Combinational per-pixel point operation                 |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module pixel_op_alu
    import pixel_op_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [1:0]    mode,
    input  logic [DW-1:0] value,
    input  logic          sub,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_g,
    input  logic [DW-1:0] in_b,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_g,
    output logic [DW-1:0] out_b,
    output logic          clipped
);

    localparam logic [c_MAX_DW-1:0] c_PIX_MAX = (c_MAX_DW'(1) << DW) - c_MAX_DW'(1);

    pixel_t              w_in;
    pixel_t              w_sat;
    logic [c_MAX_DW-1:0] w_v;
    logic                w_clip_r;
    logic                w_clip_g;
    logic                w_clip_b;
    logic [DW+1:0]       w_sum;
    logic [DW-1:0]       w_gray;
    logic [DW-1:0]       w_bin;
    logic                w_unused_hi;

    assign w_in = '{r: c_MAX_DW'(in_r), g: c_MAX_DW'(in_g), b: c_MAX_DW'(in_b)};
    assign w_v  = c_MAX_DW'(value);

    always_comb begin
        w_clip_r = 1'b0;
        w_clip_g = 1'b0;
        w_clip_b = 1'b0;
        w_sat    = '0;
        w_sat.r  = sat_addsub(w_in.r, w_v, c_PIX_MAX, sub, w_clip_r);
        w_sat.g  = sat_addsub(w_in.g, w_v, c_PIX_MAX, sub, w_clip_g);
        w_sat.b  = sat_addsub(w_in.b, w_v, c_PIX_MAX, sub, w_clip_b);
    end

    // Luma approximation (R + 2G + B) / 4 needs two guard bits.
    assign w_sum  = {2'b00, in_r} + {1'b0, in_g, 1'b0} + {2'b00, in_b};
    assign w_gray = w_sum[DW+1:2];
    assign w_bin  = (w_gray >= value) ? {DW{1'b1}} : {DW{1'b0}};

    assign w_unused_hi = ^{w_sat.r[c_MAX_DW-1:DW], w_sat.g[c_MAX_DW-1:DW],
                           w_sat.b[c_MAX_DW-1:DW], w_sum[1:0]};

    always_comb begin
        out_r   = in_r;
        out_g   = in_g;
        out_b   = in_b;
        clipped = 1'b0;
        case (mode)
            MODE_BRIGHT: begin
                out_r   = w_sat.r[DW-1:0];
                out_g   = w_sat.g[DW-1:0];
                out_b   = w_sat.b[DW-1:0];
                clipped = w_clip_r | w_clip_g | w_clip_b;
            end
            MODE_GRAY: begin
                out_r = w_gray;
                out_g = w_gray;
                out_b = w_gray;
            end
            MODE_THRESH: begin
                out_r = w_bin;
                out_g = w_bin;
                out_b = w_bin;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pixel_point_op.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : pixel_point_op                                          |
// | Purpose  : Two-stage streaming point operation with frame tagging. |
// |            Define PIXEL_STATS_EN to enable saturated-pixel stats.  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module pixel_point_op
    import pixel_op_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DIM_W = 32
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [1:0]       cfg_mode,
    input  logic [DW-1:0]    cfg_value,
    input  logic             cfg_sub,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_r,
    input  logic [DW-1:0]    s_g,
    input  logic [DW-1:0]    s_b,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_r,
    output logic [DW-1:0]    m_g,
    output logic [DW-1:0]    m_b,
    output logic             m_eol,
    output logic             m_eof,
    output logic             busy,
    output logic [DIM_W-1:0] sat_count
);

    logic             r_rdy_en;
    logic             r_v1;
    logic             r_v2;
    logic [DW-1:0]    r_r1, r_g1, r_b1;
    logic             r_eol1, r_eof1;
    logic [DW-1:0]    r_m_r, r_m_g, r_m_b;
    logic             r_m_eol, r_m_eof;
    logic [DIM_W-1:0] r_col, r_row;
    logic [DIM_W-1:0] r_width, r_height;
    logic [1:0]       r_mode;
    logic [DW-1:0]    r_value;
    logic             r_sub;
    logic             r_busy;

    logic             w_ld1, w_ld2, w_acc, w_first;
    logic [1:0]       w_mode;
    logic [DW-1:0]    w_value;
    logic             w_sub;
    logic [DIM_W-1:0] w_width, w_height, w_w_last, w_h_last;
    logic             w_eol, w_eof, w_eof_done;
    logic [DW-1:0]    w_alu_r, w_alu_g, w_alu_b;
    logic             w_clipped;

    assign w_ld2   = !r_v2 | m_ready;
    assign w_ld1   = !r_v1 | w_ld2;
    assign s_ready = r_rdy_en & w_ld1;
    assign w_acc   = s_valid & s_ready;

    // The first pixel of a frame must use the live config, since the latch
    // only captures it on that same edge.
    assign w_first  = (r_col == '0) && (r_row == '0);
    assign w_mode   = w_first ? cfg_mode  : r_mode;
    assign w_value  = w_first ? cfg_value : r_value;
    assign w_sub    = w_first ? cfg_sub   : r_sub;
    assign w_width  = w_first ? width     : r_width;
    assign w_height = w_first ? height    : r_height;

    assign w_w_last = (w_width  == '0) ? '0 : w_width  - DIM_W'(1);
    assign w_h_last = (w_height == '0) ? '0 : w_height - DIM_W'(1);
    assign w_eol    = (r_col == w_w_last);
    assign w_eof    = w_eol && (r_row == w_h_last);

    assign w_eof_done = r_v2 & m_ready & r_m_eof;

    pixel_op_alu #(
        .DW (DW)
    ) u_alu (
        .mode    (w_mode),
        .value   (w_value),
        .sub     (w_sub),
        .in_r    (s_r),
        .in_g    (s_g),
        .in_b    (s_b),
        .out_r   (w_alu_r),
        .out_g   (w_alu_g),
        .out_b   (w_alu_b),
        .clipped (w_clipped)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_rdy_en <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
            r_width  <= '0;
            r_height <= '0;
            r_mode   <= MODE_BYPASS;
            r_value  <= '0;
            r_sub    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_acc && w_first) begin
                r_mode   <= cfg_mode;
                r_value  <= cfg_value;
                r_sub    <= cfg_sub;
                r_width  <= width;
                r_height <= height;
            end
            if (w_acc) begin
                if (w_eol) begin
                    r_col <= '0;
                    r_row <= w_eof ? '0 : r_row + DIM_W'(1);
                end else begin
                    r_col <= r_col + DIM_W'(1);
                end
            end
            if (w_acc && w_first) begin
                r_busy <= 1'b1;
            end else if (w_eof_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_v1    <= 1'b0;
            r_r1    <= '0;
            r_g1    <= '0;
            r_b1    <= '0;
            r_eol1  <= 1'b0;
            r_eof1  <= 1'b0;
            r_v2    <= 1'b0;
            r_m_r   <= '0;
            r_m_g   <= '0;
            r_m_b   <= '0;
            r_m_eol <= 1'b0;
            r_m_eof <= 1'b0;
        end else begin
            if (w_ld1) begin
                r_v1 <= w_acc;
                if (w_acc) begin
                    r_r1   <= w_alu_r;
                    r_g1   <= w_alu_g;
                    r_b1   <= w_alu_b;
                    r_eol1 <= w_eol;
                    r_eof1 <= w_eof;
                end
            end
            if (w_ld2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_m_r   <= r_r1;
                    r_m_g   <= r_g1;
                    r_m_b   <= r_b1;
                    r_m_eol <= r_eol1;
                    r_m_eof <= r_eof1;
                end
            end
        end
    end

    assign m_valid = r_v2;
    assign m_r     = r_m_r;
    assign m_g     = r_m_g;
    assign m_b     = r_m_b;
    assign m_eol   = r_m_eol;
    assign m_eof   = r_m_eof;
    assign busy    = r_busy;

`ifdef PIXEL_STATS_EN
    logic [DIM_W-1:0] r_sat_acc;
    logic [DIM_W-1:0] r_sat_count;

    // The eof pixel's own clip is folded into the published count.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_sat_acc   <= '0;
            r_sat_count <= '0;
        end else if (w_acc) begin
            if (w_eof) begin
                r_sat_count <= r_sat_acc + DIM_W'(w_clipped);
                r_sat_acc   <= '0;
            end else if (w_clipped) begin
                r_sat_acc <= r_sat_acc + DIM_W'(1);
            end
        end
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused_clip;
    assign w_unused_clip = w_clipped;
    assign sat_count     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_point_op.sv
`default_nettype none
// Self-checking bench for pixel_point_op: directed vector table, frame
// sequences and randomized traffic against a behavioural scoreboard.
module tb_pixel_point_op;

    logic        HCLK;
    logic        HRESET;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_value;
    logic        cfg_sub;
    logic [31:0] width;
    logic [31:0] height;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_r, s_g, s_b;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_r, m_g, m_b;
    logic        m_eol;
    logic        m_eof;
    logic        busy;
    logic [31:0] sat_count;

`ifdef PIXEL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    pixel_point_op #(.DW(8), .DIM_W(32)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cfg_mode  (cfg_mode),
        .cfg_value (cfg_value),
        .cfg_sub   (cfg_sub),
        .width     (width),
        .height    (height),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_r       (s_r),
        .s_g       (s_g),
        .s_b       (s_b),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_r       (m_r),
        .m_g       (m_g),
        .m_b       (m_b),
        .m_eol     (m_eol),
        .m_eof     (m_eof),
        .busy      (busy),
        .sat_count (sat_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT at t=%0t", name, $time);
    endtask

    // Behavioural reference from the arithmetic rules, in plain integers.
    function automatic void ref_px(input int mode, input int v, input bit sub,
                                   input int r, input int g, input int b,
                                   output int o_r, output int o_g, output int o_b,
                                   output bit clip);
        int c[3];
        int t;
        int gy;
        c[0] = r; c[1] = g; c[2] = b;
        clip = 1'b0;
        gy = (r + 2 * g + b) / 4;
        case (mode)
            1: for (int i = 0; i < 3; i++) begin
                t = sub ? c[i] - v : c[i] + v;
                if (t < 0) begin t = 0; clip = 1'b1; end
                else if (t > 255) begin t = 255; clip = 1'b1; end
                c[i] = t;
            end
            2: begin c[0] = gy; c[1] = gy; c[2] = gy; end
            3: begin
                t = (gy >= v) ? 255 : 0;
                c[0] = t; c[1] = t; c[2] = t;
            end
            default: ;
        endcase
        o_r = c[0]; o_g = c[1]; o_b = c[2];
    endfunction

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       eol;
        logic       eof;
    } out_t;

    out_t exp_q[$];
    out_t md_e;
    out_t mon_e;
    int   md_k = 0, md_fw = 1, md_fh = 1, md_mode = 0, md_val = 0;
    bit   md_sub = 1'b0;
    int   md_sat_acc = 0, md_last_sat = 0;
    bit   sat_pending = 1'b0;
    bit   hold = 1'b0;
    logic [25:0] hold_val;
    int   ro, go, bo;
    bit   clip;
    int   eol_seen = 0, eof_seen = 0;

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge HCLK) begin
        if (HRESET) begin
            exp_q.delete();
            md_k = 0; md_sat_acc = 0; md_last_sat = 0;
            sat_pending = 1'b0;
            hold = 1'b0;
        end else begin
            if (sat_pending) begin
                chk("sat_count_frame", 64'(sat_count), STATS ? 64'(md_last_sat) : 64'(0));
                sat_pending = 1'b0;
            end
            if (hold) begin
                chk("hold_stable", 64'({m_valid, m_r, m_g, m_b, m_eol, m_eof}), 64'({1'b1, hold_val}));
            end
            hold     = m_valid && !m_ready;
            hold_val = {m_r, m_g, m_b, m_eol, m_eof};
            if (m_valid && m_ready) begin
                if (m_eol) eol_seen++;
                if (m_eof) eof_seen++;
                if (exp_q.size() == 0) begin
                    timeout_fail("spurious_output");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_pixel", 64'({m_r, m_g, m_b, m_eol, m_eof}), 64'(mon_e));
                end
            end
            if (s_valid && s_ready) begin
                if (md_k == 0) begin
                    md_mode = int'(cfg_mode);
                    md_val  = int'(cfg_value);
                    md_sub  = cfg_sub;
                    md_fw   = (width  == 0) ? 1 : int'(width);
                    md_fh   = (height == 0) ? 1 : int'(height);
                end
                ref_px(md_mode, md_val, md_sub, int'(s_r), int'(s_g), int'(s_b), ro, go, bo, clip);
                md_e.r   = 8'(ro);
                md_e.g   = 8'(go);
                md_e.b   = 8'(bo);
                md_e.eol = ((md_k + 1) % md_fw) == 0;
                md_e.eof = (md_k + 1) == md_fw * md_fh;
                exp_q.push_back(md_e);
                if (clip) md_sat_acc++;
                if (md_e.eof) begin
                    md_k = 0;
                    md_last_sat = md_sat_acc;
                    md_sat_acc  = 0;
                    sat_pending = 1'b1;
                end else begin
                    md_k++;
                end
            end
        end
    end

    task automatic set_cfg(input int mode, input int v, input bit sub, input int w, input int h);
        cfg_mode  = 2'(mode);
        cfg_value = 8'(v);
        cfg_sub   = sub;
        width     = 32'(w);
        height    = 32'(h);
    endtask

    // Streams n pixels, optionally stalling the sink for a window of cycles.
    task automatic send_frame(input int n, input int base, input int st_from, input int st_len);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < n && cyc < 200) begin
            s_valid = 1'b1;
            s_r = 8'(base + idx * 37);
            s_g = 8'(base * 3 + idx * 11);
            s_b = 8'(200 + idx * 5 + base);
            m_ready = !(cyc >= st_from && cyc < st_from + st_len);
            @(negedge HCLK);
            if (st_len > 0 && cyc == st_from + st_len - 1)
                chk("backpressure_s_ready", 64'(s_ready), 64'(0));
            acc = s_valid && s_ready;
            @(posedge HCLK); #1;
            if (acc) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        if (idx < n) timeout_fail("send_frame");
    endtask

    task automatic drain();
        int guard = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge HCLK); #1;
            guard++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
        @(posedge HCLK); #1;
    endtask

    typedef struct {
        int mode; int val; bit sub;
        int r; int g; int b;
        int er; int eg; int eb;
        int esat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int eol0, eof0;
        tbl[0] = '{1, 100, 1'b0, 200,  50,   0, 255, 150, 100, 1};
        tbl[1] = '{1,  60, 1'b1,  50, 100, 255,   0,  40, 195, 1};
        tbl[2] = '{2,   0, 1'b0, 100, 200,  40, 135, 135, 135, 0};
        tbl[3] = '{3, 128, 1'b0, 100, 200,  40, 255, 255, 255, 0};
        tbl[4] = '{0,  77, 1'b1,   1,   2,   3,   1,   2,   3, 0};
        tbl[5] = '{3, 136, 1'b0, 100, 200,  40,   0,   0,   0, 0};
        tbl[6] = '{3, 135, 1'b0, 100, 200,  40, 255, 255, 255, 0};
        tbl[7] = '{1,   0, 1'b1,   7,   8,   9,   7,   8,   9, 0};
        tbl[8] = '{2,   0, 1'b0, 255, 255, 255, 255, 255, 255, 0};
        tbl[9] = '{1, 255, 1'b0,   0,   0,   0, 255, 255, 255, 0};

        HRESET  = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        s_r = '0; s_g = '0; s_b = '0;
        set_cfg(0, 0, 1'b0, 1, 1);
        @(posedge HCLK); @(posedge HCLK); #1;
        chk("reset_m_valid", 64'(m_valid), 64'(0));
        chk("reset_m_data", 64'({m_r, m_g, m_b, m_eol, m_eof}), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_sat_count", 64'(sat_count), 64'(0));
        HRESET = 1'b0;
        #1;
        chk("s_ready_before_edge", 64'(s_ready), 64'(0));
        @(posedge HCLK); #1;
        chk("s_ready_after_edge", 64'(s_ready), 64'(1));

        // Directed single-pixel frames with latency check.
        for (int i = 0; i < 10; i++) begin
            set_cfg(tbl[i].mode, tbl[i].val, tbl[i].sub, 1, 1);
            s_r = 8'(tbl[i].r); s_g = 8'(tbl[i].g); s_b = 8'(tbl[i].b);
            s_valid = 1'b1;
            @(negedge HCLK);
            chk($sformatf("tbl%0d_s_ready", i), 64'(s_ready), 64'(1));
            @(posedge HCLK); #1;
            s_valid = 1'b0;
            @(posedge HCLK); #1;
            chk($sformatf("tbl%0d_m_valid", i), 64'(m_valid), 64'(1));
            chk($sformatf("tbl%0d_rgb", i), 64'({m_r, m_g, m_b}),
                64'({8'(tbl[i].er), 8'(tbl[i].eg), 8'(tbl[i].eb)}));
            chk($sformatf("tbl%0d_tags", i), 64'({m_eol, m_eof}), 64'(2'b11));
            chk($sformatf("tbl%0d_sat", i), 64'(sat_count), STATS ? 64'(tbl[i].esat) : 64'(0));
        end
        drain();

        // 4x2 frame, twice: eol/eof positions and busy lifetime.
        set_cfg(1, 10, 1'b0, 4, 2);
        for (int f = 0; f < 2; f++) begin
            eol0 = eol_seen; eof0 = eof_seen;
            send_frame(8, 5 + f * 4, 0, 0);
            chk("frame_busy_high", 64'(busy), 64'(1));
            drain();
            chk("frame_busy_low", 64'(busy), 64'(0));
            chk("frame_eol_count", 64'(eol_seen - eol0), 64'(2));
            chk("frame_eof_count", 64'(eof_seen - eof0), 64'(1));
        end

        // Sink stalls for 5 cycles mid-stream.
        set_cfg(0, 0, 1'b0, 8, 1);
        send_frame(8, 40, 3, 5);
        drain();

        // Mode change mid-frame only takes effect on the next frame.
        set_cfg(1, 50, 1'b0, 4, 1);
        send_frame(2, 60, 0, 0);
        cfg_mode = 2'd2;
        send_frame(2, 70, 0, 0);
        send_frame(4, 80, 0, 0);
        drain();

        // Reset in the middle of a frame.
        set_cfg(3, 100, 1'b0, 4, 2);
        eof0 = eof_seen;
        send_frame(3, 90, 0, 0);
        HRESET = 1'b1;
        #1;
        chk("midreset_m_valid", 64'(m_valid), 64'(0));
        chk("midreset_busy", 64'(busy), 64'(0));
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        chk("midreset_s_ready", 64'(s_ready), 64'(1));
        chk("midreset_no_eof", 64'(eof_seen - eof0), 64'(0));
        eol0 = eol_seen; eof0 = eof_seen;
        send_frame(8, 100, 0, 0);
        drain();
        chk("post_reset_eol", 64'(eol_seen - eol0), 64'(2));
        chk("post_reset_eof", 64'(eof_seen - eof0), 64'(1));
        chk("post_reset_busy", 64'(busy), 64'(0));

        // Randomized traffic; config churns every cycle.
        for (int c = 0; c < 600; c++) begin
            set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 3)));
            s_valid = ($urandom_range(0, 3) != 0);
            s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            @(posedge HCLK); #1;
        end
        drain();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
